debounce_multi: RTL and testbench
=================================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter CLK_FREQ, default 12_000_000, SHALL be the clk frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 20, SHALL be the stability window in ms; MAX_COUNT = CLK_FREQ/1000*DEBOUNCE_MS - 1, which SHALL be >= 1.
REQ-003 Parameter N_CH, default 4, SHALL be the channel count, N_CH >= 1.
REQ-004 Parameter ACTIVE_LOW, default 0; when 1, the synchronised input SHALL be inverted before debouncing.
REQ-005 Parameter HOLD_MS, default 500, SHALL be the long-press delay; HOLD_CYC = CLK_FREQ/1000*HOLD_MS, which SHALL be >= 2.
REQ-006 Parameter REPEAT_MS, default 100, SHALL be the auto-repeat period; REP_CYC = CLK_FREQ/1000*REPEAT_MS, which SHALL be >= 2.
REQ-007 clk  input  1  sole clock, all logic on the rising edge.
REQ-008 rst  input  1  reset; synchronous, active-high.
REQ-009 noisy_in  input  N_CH  asynchronous raw inputs, one bit per channel.
REQ-010 level  output  N_CH  debounced, polarity-corrected state per channel.
REQ-011 press_pulse  output  N_CH  one-cycle pulse on each debounced 0->1 transition.
REQ-012 release_pulse  output  N_CH  one-cycle pulse on each debounced 1->0 transition.
REQ-013 repeat_pulse  output  N_CH  one-cycle long-press/auto-repeat pulse; the port SHALL always exist.

Function
REQ-014 Each channel SHALL be fully independent; simultaneous events on several channels SHALL be handled in parallel with no interaction.
REQ-015 Each channel SHALL pass noisy_in through a 2-flop synchroniser, followed by the ACTIVE_LOW inversion.
REQ-016 Counter width SHALL be $clog2(MAX_COUNT+1); the counter SHALL clear in any cycle where the synced value equals level.
REQ-017 While the synced value differs from level, the counter SHALL increment; at counter==MAX_COUNT, level SHALL toggle and the counter SHALL clear on the same edge.
REQ-018 A stable input change SHALL reach level on the (MAX_COUNT+3)th rising edge, counting the edge that first samples it.
REQ-019 Any bounce returning to level before MAX_COUNT is reached SHALL cause no level change and no pulse.
REQ-020 press_pulse/release_pulse SHALL be registered and assert on the same edge that level changes, for exactly one cycle.
REQ-021 The repeat FSM per channel SHALL have states IDLE, HOLD and REPEAT, driven by a hold counter of width $clog2(max(HOLD_CYC,REP_CYC)+1).
REQ-022 IDLE->HOLD SHALL occur on the press edge, with the counter cleared.
REQ-023 HOLD->REPEAT SHALL occur HOLD_CYC edges after the press edge, with repeat_pulse asserted for one cycle.
REQ-024 In REPEAT, repeat_pulse SHALL assert every REP_CYC edges.
REQ-025 Any state SHALL return to IDLE on the edge where level falls; no repeat_pulse SHALL be issued on that edge.

Reset
REQ-026 rst SHALL clear synchronisers, counters, level, all pulse outputs and the FSM (to IDLE) on the next edge, including mid-count.
REQ-027 No pulse SHALL be generated by reset itself; an input held active through reset release SHALL produce press_pulse MAX_COUNT+3 edges after release.

Configuration
REQ-028 With macro DEBOUNCE_REPEAT_EN defined, the repeat FSM and hold counter SHALL be compiled in per REQ-021..025.
REQ-029 Without DEBOUNCE_REPEAT_EN, no FSM or hold counter SHALL be synthesised and repeat_pulse SHALL be constant 0.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4 => MAX_COUNT=3, HOLD_MS=10, REPEAT_MS=5, N_CH=4)
REQ-030 Step ch0 0->1 and hold -> level[0] and press_pulse[0] rise on the 6th edge; press_pulse[0] is high for 1 cycle.
REQ-031 Pulse ch1 high for 3 cycles, then low -> no level change, no pulses.
REQ-032 Hold ch2 for 40 cycles with DEBOUNCE_REPEAT_EN -> repeat_pulse[2] at press+10, +15, +20...; release -> release_pulse[2] and no further repeats; without the macro -> repeat_pulse stays 0.
REQ-033 Step ch0 and ch3 on the same edge -> identical timing on both; other channels stay quiet.
REQ-034 Assert rst mid-count and mid-REPEAT -> all outputs 0 on the next edge; with input still high, press_pulse occurs 6 edges after rst release.
REQ-035 ACTIVE_LOW=1, input idles at 1, drops to 0 -> press_pulse after 6 edges; returns to 1 -> release_pulse after 6 edges.

Source files
------------

// File: rtl/debounce_multi.sv
// debounce_multi
//   Multi-channel push-button debouncer. Every channel is synchronised,
//   optionally polarity-inverted, and debounced by a per-channel stability
//   counter. Each debounced edge produces a one-cycle press or release pulse.
//   An optional long-press / auto-repeat generator can be compiled in by
//   defining the macro DEBOUNCE_REPEAT_EN. In the default build that macro
//   is undefined and repeat_pulse is tied to zero.
//
// Ports
//   clk            sole clock, everything on the rising edge
//   rst            synchronous, active-high reset
//   noisy_in       [N_CH] raw asynchronous button inputs
//   level          [N_CH] debounced, polarity-corrected button state
//   press_pulse    [N_CH] one-cycle pulse on each debounced 0->1 edge
//   release_pulse  [N_CH] one-cycle pulse on each debounced 1->0 edge
//   repeat_pulse   [N_CH] one-cycle long-press / auto-repeat pulse
module debounce_multi #(
  parameter int CLK_FREQ    = 12_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int N_CH        = 4,
  parameter int ACTIVE_LOW  = 0,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int MAX_COUNT = CLK_FREQ / 1000 * DEBOUNCE_MS - 1;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);
  localparam int HOLD_CYC  = CLK_FREQ / 1000 * HOLD_MS;
  localparam int REP_CYC   = CLK_FREQ / 1000 * REPEAT_MS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT);

  // Reject parameter sets that would make the counters meaningless.
  generate
    if (MAX_COUNT < 1) begin : g_chk_max
      $error("debounce_multi: MAX_COUNT must be at least 1");
    end
    if (HOLD_CYC < 2) begin : g_chk_hold
      $error("debounce_multi: HOLD_CYC must be at least 2");
    end
    if (REP_CYC < 2) begin : g_chk_rep
      $error("debounce_multi: REP_CYC must be at least 2");
    end
    if (N_CH < 1) begin : g_chk_nch
      $error("debounce_multi: N_CH must be at least 1");
    end
  endgenerate

  logic [N_CH-1:0] sync_a;
  logic [N_CH-1:0] sync_b;
  logic [N_CH-1:0] synced;
  logic [N_CH-1:0] differs;
  logic [N_CH-1:0] toggle;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= noisy_in;
      sync_b <= sync_a;
    end
  end

  // Inversion sits after the synchroniser so both flops see the raw pin.
  assign synced  = (ACTIVE_LOW != 0) ? ~sync_b : sync_b;
  assign differs = synced ^ level;

  // Per-channel stability counter: it only runs while the synced input
  // disagrees with level, so any bounce back to level restarts the window.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_deb
    logic [CNT_W-1:0] cnt;

    assign toggle[ch] = differs[ch] && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
      if (rst || !differs[ch] || toggle[ch]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = toggle & ~level;
  assign fall = toggle & level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level         <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      level         <= level ^ toggle;
      press_pulse   <= rise;
      release_pulse <= fall;
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  localparam int HR_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int HCNT_W = $clog2(HR_MAX + 1);

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYC - 1);
  localparam logic [HCNT_W-1:0] REP_LAST  = HCNT_W'(REP_CYC - 1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_rep
    rep_state_t        state_q;
    rep_state_t        state_d;
    logic [HCNT_W-1:0] hcnt_q;
    logic [HCNT_W-1:0] hcnt_d;
    logic              rep_q;
    logic              rep_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        rep_q   <= rep_d;
      end
    end

    // The hold counter is cleared on the press edge, so it holds k-1 just
    // before the k-th edge after the press; comparing against CYC-1 fires
    // exactly HOLD_CYC / REP_CYC edges later.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q + HCNT_W'(1);
      rep_d   = 1'b0;
      case (state_q)
        IDLE: begin
          hcnt_d = '0;
          if (rise[ch]) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            state_d = REPEAT;
            hcnt_d  = '0;
            rep_d   = 1'b1;
          end
        end
        REPEAT: begin
          if (hcnt_q == REP_LAST) begin
            hcnt_d = '0;
            rep_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hcnt_d  = '0;
        end
      endcase
      // A release wins over any repeat that would coincide with it.
      if (fall[ch]) begin
        state_d = IDLE;
        hcnt_d  = '0;
        rep_d   = 1'b0;
      end
    end

    assign repeat_pulse[ch] = rep_q;
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi
//   Self-checking bench for debounce_multi. Two instances share clk/rst:
//   one active-high, one active-low. A behavioural model derives the
//   expected outputs every cycle from the stimulus history: level flips
//   once the synchronised input has disagreed with it for MAX_COUNT+1
//   consecutive non-reset cycles, and repeats fall at HOLD_CYC + k*REP_CYC
//   edges after the press while the button stays down.
module tb_debounce_multi;

  localparam int CLK_FREQ    = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int HOLD_MS     = 10;
  localparam int REPEAT_MS   = 5;
  localparam int N_CH        = 4;
  localparam int MAX_COUNT   = CLK_FREQ / 1000 * DEBOUNCE_MS - 1;
  localparam int HOLD_CYC    = CLK_FREQ / 1000 * HOLD_MS;
  localparam int REP_CYC     = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int NE          = 4096;
  localparam logic [N_CH-1:0] AL_IDLE = '1;
`ifdef DEBOUNCE_REPEAT_EN
  localparam int EXP_REPEATS = 6;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] noisy_in;
  logic [N_CH-1:0] noisy_al;
  logic [N_CH-1:0] level, press_pulse, release_pulse, repeat_pulse;
  logic [N_CH-1:0] al_level, al_press, al_release, al_repeat;

  int tests_run    = 0;
  int tests_failed = 0;

  debounce_multi #(
    .CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS), .N_CH(N_CH),
    .ACTIVE_LOW(0), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk(clk), .rst(rst), .noisy_in(noisy_in), .level(level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  debounce_multi #(
    .CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS), .N_CH(N_CH),
    .ACTIVE_LOW(1), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)
  ) dut_al (
    .clk(clk), .rst(rst), .noisy_in(noisy_al), .level(al_level),
    .press_pulse(al_press), .release_pulse(al_release),
    .repeat_pulse(al_repeat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Stimulus history and model state; index 0 = active-high, 1 = active-low.
  logic [N_CH-1:0] raw_h [2][NE];
  bit              rst_h [NE];
  int              e_cnt = 0;
  logic [N_CH-1:0] m_lvl [2];
  logic [N_CH-1:0] m_prs [2];
  logic [N_CH-1:0] m_rel [2];
  logic [N_CH-1:0] m_rep [2];
  int              press_at [2][N_CH];

  // Polarity-corrected value the debouncer compares at edge j: the input
  // sampled two edges earlier, or the cleared synchroniser after a reset.
  function automatic logic seenVal(input int k, input int j, input int ch);
    logic inv;
    inv = (k == 1);
    if (j < 2 || rst_h[j-1] || rst_h[j-2]) return inv;
    return raw_h[k][j-2][ch] ^ inv;
  endfunction

  task automatic modelStep(input int k, input int e);
    logic [N_CH-1:0] flip;
    logic            rep;
    int              d;
    if (rst_h[e]) begin
      m_lvl[k] = '0;
      m_prs[k] = '0;
      m_rel[k] = '0;
      m_rep[k] = '0;
      for (int ch = 0; ch < N_CH; ch++) press_at[k][ch] = -1;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        flip[ch] = 1'b1;
        for (int j = e - MAX_COUNT; j <= e; j++) begin
          if (j < 0 || rst_h[j] || seenVal(k, j, ch) == m_lvl[k][ch]) flip[ch] = 1'b0;
        end
        rep = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
        if (m_lvl[k][ch] && !flip[ch] && press_at[k][ch] >= 0) begin
          d = e - press_at[k][ch];
          if (d >= HOLD_CYC && (d - HOLD_CYC) % REP_CYC == 0) rep = 1'b1;
        end
`else
        d = 0;
`endif
        m_rep[k][ch] = rep;
        if (flip[ch] && !m_lvl[k][ch]) press_at[k][ch] = e;
      end
      m_prs[k] = flip & ~m_lvl[k];
      m_rel[k] = flip & m_lvl[k];
      m_lvl[k] = m_lvl[k] ^ flip;
    end
  endtask

  always @(posedge clk) begin
    if (e_cnt < NE) begin
      rst_h[e_cnt]    = rst;
      raw_h[0][e_cnt] = noisy_in;
      raw_h[1][e_cnt] = noisy_al;
      modelStep(0, e_cnt);
      modelStep(1, e_cnt);
      e_cnt++;
    end
    #1;
    checkOutput("level",       32'(level),         32'(m_lvl[0]));
    checkOutput("press",       32'(press_pulse),   32'(m_prs[0]));
    checkOutput("release",     32'(release_pulse), 32'(m_rel[0]));
    checkOutput("repeat",      32'(repeat_pulse),  32'(m_rep[0]));
    checkOutput("al_level",    32'(al_level),      32'(m_lvl[1]));
    checkOutput("al_press",    32'(al_press),      32'(m_prs[1]));
    checkOutput("al_release",  32'(al_release),    32'(m_rel[1]));
    checkOutput("al_repeat",   32'(al_repeat),     32'(m_rep[1]));
  end

  // Drive inputs on the falling edge and hold them for n rising edges.
  task automatic applyStimulus(input logic r, input logic [N_CH-1:0] a,
                               input logic [N_CH-1:0] b, input int n);
    @(negedge clk);
    rst      = r;
    noisy_in = a;
    noisy_al = b;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int              found;
    int              rep_cnt;
    logic            r;
    logic [N_CH-1:0] cur;
    logic [N_CH-1:0] cur_al;

    rst      = 1'b1;
    noisy_in = '0;
    noisy_al = AL_IDLE;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_press", 32'(press_pulse), 32'd0);

    applyStimulus(0, 4'b0000, AL_IDLE, 4);

    // ch0 step: level and press on the 6th edge, press lasts one cycle
    @(negedge clk);
    noisy_in = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #2;
      if (k == 5) checkOutput("step_e5_level", 32'(level[0]), 32'd0);
      if (k == 6) begin
        checkOutput("step_e6_level", 32'(level[0]), 32'd1);
        checkOutput("step_e6_press", 32'(press_pulse[0]), 32'd1);
      end
      if (k == 7) checkOutput("step_e7_press", 32'(press_pulse[0]), 32'd0);
    end
    applyStimulus(0, 4'b0001, AL_IDLE, 4);
    applyStimulus(0, 4'b0000, AL_IDLE, 10);

    // ch1 three-cycle glitch must be swallowed
    applyStimulus(0, 4'b0010, AL_IDLE, 3);
    applyStimulus(0, 4'b0000, AL_IDLE, 10);
    checkOutput("glitch_level", 32'(level[1]), 32'd0);

    // ch2 long hold: count repeat pulses up to and past the release
    rep_cnt = 0;
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      noisy_in = (k < 40) ? 4'b0100 : 4'b0000;
      @(posedge clk);
      #2;
      if (repeat_pulse[2]) rep_cnt++;
    end
    checkOutput("ch2_repeat_count", 32'(rep_cnt), 32'(EXP_REPEATS));

    // ch0 and ch3 together
    applyStimulus(0, 4'b1001, AL_IDLE, 12);
    applyStimulus(0, 4'b0000, AL_IDLE, 12);

    // reset mid-count, input still high through release
    applyStimulus(0, 4'b0010, AL_IDLE, 3);
    applyStimulus(1, 4'b0010, AL_IDLE, 1);
    @(negedge clk);
    rst   = 1'b0;
    found = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #2;
      if (found == 0 && press_pulse[1]) found = k;
    end
    checkOutput("rst_release_press_edge", 32'(found), 32'(MAX_COUNT + 3));
    applyStimulus(0, 4'b0000, AL_IDLE, 10);

    // reset during auto-repeat, then keep holding
    applyStimulus(0, 4'b0100, AL_IDLE, 25);
    applyStimulus(1, 4'b0100, AL_IDLE, 1);
    @(posedge clk);
    #2;
    checkOutput("rst_rep_outputs", 32'({level, press_pulse, repeat_pulse}), 32'd0);
    applyStimulus(0, 4'b0100, AL_IDLE, 20);
    applyStimulus(0, 4'b0000, AL_IDLE, 10);

    // active-low instance: press on drop to 0, release on return to 1
    applyStimulus(0, 4'b0000, 4'b1110, 12);
    applyStimulus(0, 4'b0000, AL_IDLE, 12);

    // random bouncing on both instances with occasional resets
    cur    = '0;
    cur_al = AL_IDLE;
    for (int k = 0; k < 400; k++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 11) == 0) cur[ch] = ~cur[ch];
        if ($urandom_range(0, 11) == 0) cur_al[ch] = ~cur_al[ch];
      end
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(r, cur, cur_al, 1);
    end
    applyStimulus(0, 4'b0000, AL_IDLE, 20);
    @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
